pll_lock_seq: RTL
=================

Name: pll_lock_seq

Overview:
- Multi-channel PLL lock supervisor and reset sequencer, running on the PLL reference clock domain.
- Synchronises N asynchronous PLL locked indications and debounces each one.
- Releases per-channel downstream resets in a staggered order once every PLL is stably locked.
- Re-asserts all resets on any loss of lock, and keeps per-channel sticky loss flags and saturating loss counters for software/debug.

Parameters:
- NUM_CH, 4, number of PLL channels supervised (1..16).
- SYNC_STAGES, 2, synchroniser flops per locked input (>=2).
- LOCK_STABLE_CYC, 1024, consecutive synced-high cycles before a channel counts as stable (>=1).
- RST_STAGGER_CYC, 16, cycles between successive ch_rst releases (>=1).
- CNT_W, 8, width of each loss counter.
- TIMEOUT_CYC, 65536, lock timeout; used only when PLL_LOCK_SEQ_TIMEOUT_EN is defined.

Ports:
- refclk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- pll_locked  in  NUM_CH  raw asynchronous locked inputs, bit i = channel i.
- clear_stats  in  1  one-cycle pulse; clears lost_sticky and loss_cnt.
- ch_rst  out  NUM_CH  active-high reset per downstream channel.
- all_locked  out  1  high only in RUN state.
- lost_sticky  out  NUM_CH  sticky per-channel loss-of-lock flag.
- loss_cnt  out  NUM_CH*CNT_W  saturating loss counters; channel i occupies bits [i*CNT_W +: CNT_W].
- seq_state  out  2  encoded FSM state: 0=WAIT_LOCK, 1=SEQUENCE, 2=RUN, 3=FAULT.
- lock_timeout  out  1  present only with the macro.

Behaviour:
- Reset values:
  - ch_rst = all ones.
  - all_locked = 0.
  - lost_sticky = 0.
  - loss_cnt = 0.
  - seq_state = WAIT_LOCK.
  - stable counters = 0.
  - synchroniser flops = 0.
  - lock_timeout = 0.
- Synchroniser: synced[i] is pll_locked[i] delayed by SYNC_STAGES flops.
- Debounce, per channel:
  - Counter increments while synced[i]=1 and saturates at LOCK_STABLE_CYC.
  - Any synced[i]=0 clears the counter to 0 in the same cycle.
  - stable[i] = (counter == LOCK_STABLE_CYC).
- WAIT_LOCK:
  - ch_rst all ones.
  - When all stable bits are 1, go to SEQUENCE next cycle and clear the stagger counter and channel index.
- SEQUENCE:
  - ch_rst[k] deasserts at SEQUENCE entry + k*RST_STAGGER_CYC cycles; channel 0 deasserts on the first SEQUENCE cycle, in ascending index order.
  - One cycle after ch_rst[NUM_CH-1] deasserts, go to RUN.
  - all_locked rises on entry to RUN.
- RUN:
  - ch_rst all zeros, all_locked=1.
  - Stays in RUN while every stable bit is 1.
- Loss event:
  - Defined as a falling edge of stable[i] (previous 1, now 0) in SEQUENCE or RUN.
  - Next cycle: FSM enters FAULT, ch_rst goes to all ones, all_locked goes to 0.
  - For every channel that lost lock: lost_sticky[i] is set and loss_cnt[i] increments, saturating at 2^CNT_W-1.
  - Several channels losing lock in the same cycle: each is counted.
- FAULT: lasts exactly one cycle, then WAIT_LOCK.
- Stable edges outside SEQUENCE/RUN are not counted.
- clear_stats:
  - Clears lost_sticky and loss_cnt next cycle.
  - If a loss event occurs in the same cycle, the result is lost_sticky[i]=1 and loss_cnt[i]=1 for that channel.
- rst asserted in any state: all outputs and state return to reset values on the next edge, overriding every other event.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: PLL_LOCK_SEQ_TIMEOUT_EN.
- Defined:
  - A timeout counter runs in WAIT_LOCK and clears on leaving WAIT_LOCK.
  - When it reaches TIMEOUT_CYC, lock_timeout is set; it is sticky and cleared only by rst or clear_stats.
  - The FSM keeps waiting; sequencing is unchanged.
- Undefined: the lock_timeout port and the counter do not exist.

Decomposition:
- Shared package pll_seq_pkg holds:
  - the state enum (WAIT_LOCK, SEQUENCE, RUN, FAULT with the encodings above);
  - the seq_state width constant;
  - a clog2-based width helper for the stable, stagger and timeout counters.
- One natural sub-module, pll_lock_debounce:
  - handles a single channel (synchroniser plus stable counter);
  - output is stable and a one-cycle falling-edge pulse;
  - instantiated NUM_CH times.

Test Plan:
Bench parameters: NUM_CH=4, SYNC_STAGES=2, LOCK_STABLE_CYC=16, RST_STAGGER_CYC=4, CNT_W=4.
- Power-up: rst held 5 cycles, then all pll_locked raised at cycle 0.
  - stable at cycle 18; SEQUENCE at 19.
  - ch_rst releases at 19, 23, 27, 31.
  - RUN and all_locked=1 at 32.
- Glitch: pll_locked[2] dropped for 1 cycle at debounce count 10 → counter restarts; SEQUENCE entry is delayed to 16 cycles after re-high plus sync.
- Loss in RUN: pll_locked[1] dropped → after SYNC_STAGES+1 cycles:
  - FAULT, ch_rst=4'hF, lost_sticky=4'b0010, loss_cnt[1]=1;
  - then WAIT_LOCK; re-lock repeats the staggered release.
- Saturation: 20 loss events on channel 0 → loss_cnt[0]=15; clear_stats coincident with a loss → loss_cnt[0]=1, lost_sticky[0]=1.
- rst asserted mid-SEQUENCE, after ch_rst[0] releases → next cycle ch_rst=4'hF, state WAIT_LOCK, all stats 0.
- Macro defined, TIMEOUT_CYC=100, pll_locked held 0 → lock_timeout=1 at cycle 100 of WAIT_LOCK; it stays 1 after a later lock until clear_stats.

Source files
------------

// File: rtl/pll_lock_seq_pkg.sv
// rtl/pll_lock_seq_pkg.sv - shared state encoding and counter width helper for the PLL lock sequencer
package pll_seq_pkg;

   localparam int SEQ_STATE_W = 2;

   typedef enum logic [SEQ_STATE_W-1:0] {
      WAIT_LOCK = 2'd0,
      SEQUENCE  = 2'd1,
      RUN       = 2'd2,
      FAULT     = 2'd3
   } seq_state_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pll_lock_seq_if.sv
// rtl/pll_lock_seq_if.sv - lock inputs and status outputs of pll_lock_seq; lock_timeout only with PLL_LOCK_SEQ_TIMEOUT_EN
interface pll_lock_seq_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 8
);
   import pll_seq_pkg::*;

   logic [NUM_CH-1:0]       pll_locked;
   logic                    clear_stats;
   logic [NUM_CH-1:0]       ch_rst;
   logic                    all_locked;
   logic [NUM_CH-1:0]       lost_sticky;
   logic [NUM_CH*CNT_W-1:0] loss_cnt;
   logic [SEQ_STATE_W-1:0]  seq_state;
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
   logic                    lock_timeout;
`endif

   modport master (
      output pll_locked, clear_stats,
      input  ch_rst, all_locked, lost_sticky, loss_cnt, seq_state
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
      , input lock_timeout
`endif
   );

   modport slave (
      input  pll_locked, clear_stats,
      output ch_rst, all_locked, lost_sticky, loss_cnt, seq_state
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
      , output lock_timeout
`endif
   );
endinterface

// File: rtl/pll_lock_debounce.sv
// rtl/pll_lock_debounce.sv - one channel: locked synchroniser, stable debounce counter and stable falling-edge pulse
module pll_lock_debounce
   import pll_seq_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int LOCK_STABLE_CYC = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic locked_i,
   output logic stable_o,
   output logic fall_o
);
   localparam int CW = cnt_w(LOCK_STABLE_CYC);
   localparam logic [CW-1:0] STABLE_MAX = CW'(LOCK_STABLE_CYC);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_prev_q;
   logic                   synced;

   assign synced   = sync_q[SYNC_STAGES-1];
   assign stable_o = (cnt_q == STABLE_MAX);
   assign fall_o   = stable_prev_q & ~stable_o;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], locked_i};
      cnt_d  = '0;
      if (synced) begin
         cnt_d = stable_o ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q        <= '0;
         cnt_q         <= '0;
         stable_prev_q <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         cnt_q         <= cnt_d;
         stable_prev_q <= stable_o;
      end
   end
endmodule

// File: rtl/pll_lock_seq.sv
// rtl/pll_lock_seq.sv - multi-PLL lock supervisor with staggered reset release; PLL_LOCK_SEQ_TIMEOUT_EN adds lock_timeout
module pll_lock_seq
   import pll_seq_pkg::*;
#(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int RST_STAGGER_CYC = 16,
   parameter int CNT_W           = 8
`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
   , parameter int TIMEOUT_CYC   = 65536
`endif
) (
   input logic           refclk,
   input logic           rst,
   pll_lock_seq_if.slave bus
);
   localparam int SW = cnt_w(RST_STAGGER_CYC);
   localparam int IW = cnt_w(NUM_CH - 1);
   localparam logic [SW-1:0] STAG_LAST = SW'(RST_STAGGER_CYC - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

   seq_state_e              state_q, state_d;
   logic [NUM_CH-1:0]       ch_rst_q, ch_rst_d;
   logic                    all_locked_q, all_locked_d;
   logic [NUM_CH-1:0]       sticky_q, sticky_d;
   logic [NUM_CH*CNT_W-1:0] loss_q, loss_d;
   logic [SW-1:0]           stag_q, stag_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_CH-1:0]       stable, fall;
   logic                    loss_evt;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pll_lock_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .LOCK_STABLE_CYC(LOCK_STABLE_CYC)
      ) u_deb (
         .clk_i   (refclk),
         .rst_i   (rst),
         .locked_i(bus.pll_locked[g]),
         .stable_o(stable[g]),
         .fall_o  (fall[g])
      );
   end

   assign loss_evt = ((state_q == SEQUENCE) || (state_q == RUN)) && (|fall);

   always_comb begin
      state_d      = state_q;
      ch_rst_d     = ch_rst_q;
      all_locked_d = 1'b0;
      stag_d       = stag_q;
      idx_d        = idx_q;
      sticky_d     = bus.clear_stats ? '0 : sticky_q;
      loss_d       = bus.clear_stats ? '0 : loss_q;

      case (state_q)
         WAIT_LOCK: begin
            ch_rst_d = '1;
            if (&stable) begin
               state_d     = SEQUENCE;
               stag_d      = '0;
               idx_d       = '0;
               ch_rst_d[0] = 1'b0;
            end
         end
         SEQUENCE: begin
            // idx_q is the most recently released channel
            if (idx_q == IDX_LAST) begin
               state_d      = RUN;
               ch_rst_d     = '0;
               all_locked_d = 1'b1;
            end else if (stag_q == STAG_LAST) begin
               stag_d          = '0;
               idx_d           = idx_q + 1'b1;
               ch_rst_d[idx_d] = 1'b0;
            end else begin
               stag_d = stag_q + 1'b1;
            end
         end
         RUN: begin
            ch_rst_d     = '0;
            all_locked_d = 1'b1;
         end
         FAULT: begin
            state_d  = WAIT_LOCK;
            ch_rst_d = '1;
         end
         default: state_d = WAIT_LOCK;
      endcase

      if (loss_evt) begin
         state_d      = FAULT;
         ch_rst_d     = '1;
         all_locked_d = 1'b0;
         sticky_d     = sticky_d | fall;
         for (int i = 0; i < NUM_CH; i++) begin
            if (fall[i] && (loss_d[i*CNT_W +: CNT_W] != '1)) begin
               loss_d[i*CNT_W +: CNT_W] = loss_d[i*CNT_W +: CNT_W] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q      <= WAIT_LOCK;
         ch_rst_q     <= '1;
         all_locked_q <= 1'b0;
         sticky_q     <= '0;
         loss_q       <= '0;
         stag_q       <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         ch_rst_q     <= ch_rst_d;
         all_locked_q <= all_locked_d;
         sticky_q     <= sticky_d;
         loss_q       <= loss_d;
         stag_q       <= stag_d;
         idx_q        <= idx_d;
      end
   end

   assign bus.ch_rst      = ch_rst_q;
   assign bus.all_locked  = all_locked_q;
   assign bus.lost_sticky = sticky_q;
   assign bus.loss_cnt    = loss_q;
   assign bus.seq_state   = state_q;

`ifdef PLL_LOCK_SEQ_TIMEOUT_EN
   localparam int TW = cnt_w(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_q, tmo_d;

   always_comb begin
      tmo_cnt_d = '0;
      if (state_q == WAIT_LOCK) begin
         tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
      end
      tmo_d = bus.clear_stats ? 1'b0 : (tmo_q | (tmo_cnt_d == TMO_MAX));
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tmo_q     <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tmo_q     <= tmo_d;
      end
   end

   assign bus.lock_timeout = tmo_q;
`endif
endmodule
